bp_frame_loader: RTL and testbench



---
 rtl/bp_pkg.sv | 34 +++
 rtl/bp_llr_buffer.sv | 48 ++++
 rtl/bp_frame_loader.sv | 163 ++++++++++++++++
 tb/tb_bp_frame_loader.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// bp_pkg: shared constants, state type and helpers for the N=8/K=4 BP polar decoder front end
//   LLR width, code length, information-bit set {3,5,6,7}, frozen-LLR constants
//   and the frame-loader FSM state enum.
package bp_pkg;

    localparam int BP_BIT = 8;
    localparam int BP_N = 8;
    localparam int BP_K = 4;

    localparam int INFO_IDX [BP_K] = '{3, 5, 6, 7};
    localparam logic [BP_N-1:0] INFO_MASK = 8'b1110_1000;

    localparam logic [BP_BIT-1:0] LLR_FROZEN = 8'h7F;
    localparam logic [BP_BIT-1:0] LLR_ZERO = 8'h00;

    // Cycles the loader waits for the core to raise busy after start
    localparam int WAIT_LIMIT = 4;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_START,
        ST_WAIT_BUSY,
        ST_RUN,
        ST_OUTPUT
    } loader_state_e;

    // Gathers the information bits, lowest index into bit 0
    function automatic logic [BP_K-1:0] info_bits(input logic [BP_N-1:0] b);
        logic [BP_K-1:0] r;
        for (int k = 0; k < BP_K; k++) r[k] = b[INFO_IDX[k]];
        return r;
    endfunction

endpackage

// File: rtl/bp_llr_buffer.sv
// bp_llr_buffer: N-entry write-indexed LLR register file with fill counter and flat output bus
//   clk, rst    : clock, asynchronous active-high reset
//   wr_en       : write wr_data to entry cnt and advance cnt (wraps after N-1)
//   clr         : force cnt to 0 (wins over the advance)
//   wr_data     : LLR word to store
//   cnt         : current write index
//   llr         : entry i on bits [i*BIT +: BIT]
module bp_llr_buffer #(
    parameter int BIT = 8,
    parameter int N = 8,
    localparam int CW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wr_en,
    input  logic           clr,
    input  logic [BIT-1:0] wr_data,
    output logic [CW-1:0]  cnt,
    output logic [N*BIT-1:0] llr
);

    logic [BIT-1:0] word_q [N];
    logic [BIT-1:0] word_d [N];
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        word_d = word_q;
        if (wr_en) word_d[cnt_q] = wr_data;
        cnt_d = clr ? '0 : !wr_en ? cnt_q : (cnt_q == CW'(N - 1)) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '{default: '0};
            cnt_q <= '0;
        end else begin
            word_q <= word_d;
            cnt_q <= cnt_d;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_flat
        assign llr[g*BIT +: BIT] = word_q[g];
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/bp_frame_loader.sv
// bp_frame_loader: collects N LLR words into a stable bus, starts the BP core, returns its K info bits
//   clk, rst               : clock, asynchronous active-high reset
//   s_llr_*                : LLR word stream in (valid/ready, last marks the final word)
//   dec_llr, dec_start     : frame bus and one-cycle start pulse to the core
//   dec_busy, dec_bits     : core busy flag and hard decisions
//   m_bits_*               : {bit7,bit6,bit5,bit3} result out (valid/ready)
//   frame_err              : one-cycle pulse on short frame, missing busy or run timeout
//   timeout_seen           : sticky run-timeout flag (only with BP_FRAME_LOADER_TIMEOUT_EN)
// Optional feature: define BP_FRAME_LOADER_TIMEOUT_EN to add the RUN watchdog.
module bp_frame_loader
    import bp_pkg::*;
#(
    parameter int BIT = BP_BIT,
    parameter int N = BP_N
`ifdef BP_FRAME_LOADER_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 4096
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BIT-1:0]   s_llr_data,
    input  logic             s_llr_valid,
    output logic             s_llr_ready,
    input  logic             s_llr_last,
    output logic [N*BIT-1:0] dec_llr,
    output logic             dec_start,
    input  logic             dec_busy,
    input  logic [N-1:0]     dec_bits,
    output logic [3:0]       m_bits_data,
    output logic             m_bits_valid,
    input  logic             m_bits_ready,
    output logic             frame_err
`ifdef BP_FRAME_LOADER_TIMEOUT_EN
    , output logic           timeout_seen
`endif
);

    localparam int CW = $clog2(N);

    loader_state_e state_q, state_d;
    logic [1:0] wait_q, wait_d;
    logic [BP_K-1:0] bits_q, bits_d;
    logic ready_q, ready_d;
    logic err_q, err_d;
    logic wr_en, clr;
    logic [CW-1:0] cnt;
    logic unused_bits;
`ifdef BP_FRAME_LOADER_TIMEOUT_EN
    localparam int RW = $clog2(TIMEOUT_CYCLES + 1);
    logic [RW-1:0] run_q, run_d;
    logic tmo_q, tmo_d;
`endif

    bp_llr_buffer #(.BIT(BIT), .N(N)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .clr     (clr),
        .wr_data (s_llr_data),
        .cnt     (cnt),
        .llr     (dec_llr)
    );

    always_comb begin
        state_d = state_q;
        wait_d = wait_q;
        bits_d = bits_q;
        err_d = 1'b0;
        wr_en = 1'b0;
        clr = 1'b0;
`ifdef BP_FRAME_LOADER_TIMEOUT_EN
        run_d = run_q;
        tmo_d = tmo_q;
`endif
        unique case (state_q)
            ST_LOAD: begin
                if (ready_q && s_llr_valid) begin
                    wr_en = 1'b1;
                    // A full frame is defined by the count alone; last early means a short frame
                    if (cnt == CW'(N - 1)) state_d = ST_START;
                    else if (s_llr_last) begin
                        clr = 1'b1;
                        err_d = 1'b1;
                    end
                end
            end
            ST_START: begin
                state_d = ST_WAIT_BUSY;
                wait_d = '0;
            end
            ST_WAIT_BUSY: begin
                if (dec_busy) begin
                    state_d = ST_RUN;
`ifdef BP_FRAME_LOADER_TIMEOUT_EN
                    run_d = '0;
`endif
                end else if (wait_q == 2'(WAIT_LIMIT - 1)) begin
                    state_d = ST_LOAD;
                    err_d = 1'b1;
                end else wait_d = wait_q + 2'd1;
            end
            ST_RUN: begin
                // The core updates dec_bits on the edge that drops busy, so they are valid now
                if (!dec_busy) begin
                    bits_d = info_bits(dec_bits);
                    state_d = ST_OUTPUT;
                end
`ifdef BP_FRAME_LOADER_TIMEOUT_EN
                else if (run_q == RW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_LOAD;
                    err_d = 1'b1;
                    tmo_d = 1'b1;
                end else run_d = run_q + RW'(1);
`endif
            end
            ST_OUTPUT: begin
                if (m_bits_ready) begin
                    state_d = ST_LOAD;
                    clr = 1'b1;
                end
            end
            default: state_d = ST_LOAD;
        endcase
        ready_d = state_d == ST_LOAD;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_LOAD;
            wait_q <= '0;
            bits_q <= '0;
            ready_q <= 1'b0;
            err_q <= 1'b0;
`ifdef BP_FRAME_LOADER_TIMEOUT_EN
            run_q <= '0;
            tmo_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            wait_q <= wait_d;
            bits_q <= bits_d;
            ready_q <= ready_d;
            err_q <= err_d;
`ifdef BP_FRAME_LOADER_TIMEOUT_EN
            run_q <= run_d;
            tmo_q <= tmo_d;
`endif
        end
    end

    // Frozen positions of dec_bits carry no information
    assign unused_bits = |(dec_bits & ~INFO_MASK);

    assign s_llr_ready = ready_q;
    assign dec_start = state_q == ST_START;
    assign m_bits_valid = state_q == ST_OUTPUT;
    assign m_bits_data = bits_q;
    assign frame_err = err_q;
`ifdef BP_FRAME_LOADER_TIMEOUT_EN
    assign timeout_seen = tmo_q;
`endif

endmodule

// File: tb/tb_bp_frame_loader.sv
// tb_bp_frame_loader: table-driven frames with a result scoreboard plus corner-case sequences
module tb_bp_frame_loader;

    logic clk = 1'b0;
    logic rst;
    logic [7:0] s_llr_data;
    logic s_llr_valid, s_llr_ready, s_llr_last;
    logic [63:0] dec_llr;
    logic dec_start, dec_busy;
    logic [7:0] dec_bits;
    logic [3:0] m_bits_data;
    logic m_bits_valid, m_bits_ready;
    logic frame_err;
`ifdef BP_FRAME_LOADER_TIMEOUT_EN
    logic timeout_seen;
`endif

    bp_frame_loader dut (
        .clk          (clk),
        .rst          (rst),
        .s_llr_data   (s_llr_data),
        .s_llr_valid  (s_llr_valid),
        .s_llr_ready  (s_llr_ready),
        .s_llr_last   (s_llr_last),
        .dec_llr      (dec_llr),
        .dec_start    (dec_start),
        .dec_busy     (dec_busy),
        .dec_bits     (dec_bits),
        .m_bits_data  (m_bits_data),
        .m_bits_valid (m_bits_valid),
        .m_bits_ready (m_bits_ready),
`ifdef BP_FRAME_LOADER_TIMEOUT_EN
        .timeout_seen (timeout_seen),
`endif
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] words;
        logic        last;
        int          run;
        logic [7:0]  bits;
        logic [3:0]  exp;
        int          hold;
    } vec_t;

    vec_t vecs [4];
    logic [3:0] sb [$];
    int passed = 0;
    int total = 0;
    int n_start = 0;

    // Core model: busy rises the cycle after start, stays high core_run cycles,
    // and new decisions appear on the edge that drops busy.
    logic core_en;
    int core_run;
    logic [7:0] core_bits;
    int run_left;

    always @(posedge clk) begin
        if (rst) begin
            dec_busy <= 1'b0;
            dec_bits <= '0;
            run_left <= 0;
        end else if (dec_start && core_en) begin
            dec_busy <= 1'b1;
            run_left <= core_run;
        end else if (dec_busy) begin
            run_left <= run_left - 1;
            if (run_left == 1) begin
                dec_busy <= 1'b0;
                dec_bits <= core_bits;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (dec_start) n_start++;
        if (!rst && m_bits_valid && m_bits_ready) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL sb_unexpected: got result %h with nothing expected", m_bits_data);
            end else chk("sb_data", 64'(m_bits_data), 64'(sb.pop_front()));
        end
    end

    task automatic send_word(input logic [7:0] d, input logic last, output bit ok);
        int t = 0;
        s_llr_data = d;
        s_llr_valid = 1'b1;
        s_llr_last = last;
        while (!s_llr_ready && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        ok = s_llr_ready;
        @(posedge clk); #1;
        s_llr_valid = 1'b0;
        s_llr_last = 1'b0;
    endtask

    task automatic send_frame(input vec_t v, input bit gap);
        bit ok;
        for (int i = 0; i < 8; i++) begin
            if (gap && i == 3) begin
                @(posedge clk); #1;
            end
            send_word(v.words[i*8 +: 8], (i == 7) && v.last, ok);
            if (!ok) chk("llr_hs_timeout", 64'(ok), 64'(1));
        end
    endtask

    task automatic run_frame(input vec_t v, input bit gap, input bit hold_valid);
        int t = 0;
        int s0;
        bit bad = 0;
        bit bad_hold = 0;
        core_run = v.run;
        core_bits = v.bits;
        s0 = n_start;
        send_frame(v, gap);
        sb.push_back(v.exp);
        chk("start_now", 64'(dec_start), 64'(1));
        chk("dec_llr", dec_llr, v.words);
        if (hold_valid) s_llr_valid = 1'b1;
        while (!m_bits_valid && t < v.run + 20) begin
            @(posedge clk); #1;
            t++;
            if (s_llr_ready || dec_llr !== v.words) bad = 1;
        end
        s_llr_valid = 1'b0;
        chk("latency", 64'(t), 64'(v.run + 2));
        chk("no_accept_busy", 64'(bad), 64'(0));
        chk("one_start", 64'(n_start - s0), 64'(1));
        for (int h = 0; h < v.hold; h++) begin
            @(posedge clk); #1;
            if (!m_bits_valid || m_bits_data !== v.exp) bad_hold = 1;
        end
        if (v.hold > 0) chk("valid_hold", 64'(bad_hold), 64'(0));
        m_bits_ready = 1'b1;
        @(posedge clk); #1;
        m_bits_ready = 1'b0;
        chk("valid_drop", 64'(m_bits_valid), 64'(0));
        chk("ready_back", 64'(s_llr_ready), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t;
        int s0;
        bit ok;
        vecs[0] = '{64'h40817F05E020F010, 1'b1, 200, 8'b1110_1000, 4'b1111, 3};
        vecs[1] = '{64'h0706050403020100, 1'b0, 3, 8'b0001_0111, 4'b0000, 0};
        vecs[2] = '{64'h8080807F7F7F0001, 1'b1, 1, 8'b1010_0000, 4'b1010, 1};
        vecs[3] = '{64'hFFEEDDCCBBAA9988, 1'b0, 10, 8'b0100_1000, 4'b0101, 2};
        rst = 1'b1;
        s_llr_data = '0;
        s_llr_valid = 1'b0;
        s_llr_last = 1'b0;
        m_bits_ready = 1'b0;
        core_en = 1'b1;
        core_run = 1;
        core_bits = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs", 64'({s_llr_ready, dec_start, m_bits_valid, frame_err, m_bits_data}), 64'(0));
        chk("rst_llr", dec_llr, 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst", 64'(s_llr_ready), 64'(1));

        for (int i = 0; i < 4; i++) run_frame(vecs[i], i == 0 || i == 3, i == 0);

        // Short frame: last on the third word
        s0 = n_start;
        for (int i = 0; i < 3; i++) send_word(8'(8'h30 + i), i == 2, ok);
        chk("short_err", 64'(frame_err), 64'(1));
        chk("short_ready", 64'(s_llr_ready), 64'(1));
        @(posedge clk); #1;
        chk("short_err_pulse", 64'(frame_err), 64'(0));
        chk("short_nostart", 64'(n_start - s0), 64'(0));
        run_frame(vecs[2], 1'b0, 1'b0);

        // Core never raises busy
        core_en = 1'b0;
        send_frame(vecs[1], 1'b0);
        chk("wd_start", 64'(dec_start), 64'(1));
        t = 0;
        while (!frame_err && t < 10) begin
            @(posedge clk); #1;
            t++;
        end
        chk("wd_err", 64'(frame_err), 64'(1));
        chk("wd_time", 64'(t), 64'(5));
        chk("wd_ready", 64'(s_llr_ready), 64'(1));
        @(posedge clk); #1;
        chk("wd_err_pulse", 64'(frame_err), 64'(0));
        chk("wd_no_valid", 64'(m_bits_valid), 64'(0));
        core_en = 1'b1;

        // Reset at RUN cycle 50
        core_run = 200;
        core_bits = 8'hFF;
        send_frame(vecs[0], 1'b0);
        repeat (51) @(posedge clk);
        #1;
        chk("pre_rst_busy", 64'(dec_busy), 64'(1));
        rst = 1'b1;
        #1;
        chk("async_rst_outs", 64'({s_llr_ready, dec_start, m_bits_valid, frame_err, m_bits_data}), 64'(0));
        chk("async_rst_llr", dec_llr, 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ready", 64'(s_llr_ready), 64'(1));
        run_frame(vecs[3], 1'b1, 1'b0);

        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
